// File: rtl/passcode_pkg.sv
// Shared key codes, FSM state type and helpers
// for the keypad passcode sequencer.
package passcode_pkg;

  localparam logic [3:0] KEY_ARM   = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [2:0] {
    LOCKED,
    CHECK,
    UNLOCKED,
    PROGRAM,
    LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/passcode_timer.sv
// Loadable down-counter shared by the entry timeout,
// relock and lockout intervals.
module passcode_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Fires on the Nth enabled cycle after a load of N.
  assign expired = enable & (count_q == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/passcode_controller.sv
// Keypad passcode sequencer: entry buffering, code check,
// lockout, entry timeout, auto relock and reprogramming.
module passcode_controller
  import passcode_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned           MAX_ATTEMPTS   = 3,
  parameter int unsigned           TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned           RELOCK_CYCLES  = 250_000_000,
  parameter int unsigned           LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [3:0]                      digit,
  input  logic                            valid,
  output logic                            locked,
  output logic                            unlocked,
  output logic                            alarm,
  output logic                            programming,
  output logic [$clog2(CODE_LEN+1)-1:0]   entry_count,
  output logic                            bad_code,
  output logic                            code_changed
);

  localparam int unsigned BW = CODE_LEN * 4;
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned T1 =
    (TIMEOUT_CYCLES > RELOCK_CYCLES) ? TIMEOUT_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TMAX =
    (T1 > LOCKOUT_CYCLES) ? T1 : LOCKOUT_CYCLES;
  localparam int unsigned TW = $clog2(TMAX + 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [FW-1:0]   fails_q, fails_d, fails_inc;
  logic            bad_q, bad_d;
  logic            chg_q, chg_d;
  logic            act, push, clr, full, match;
  logic            t_load, t_en, t_exp;
  logic [TW-1:0]   t_val;

  // Undefined key codes count as no event at all.
  assign act = valid & (is_digit(digit) |
                        (digit == KEY_ARM) |
                        (digit == KEY_CLEAR) |
                        (digit == KEY_ENTER));

  assign full  = (cnt_q == CW'(CODE_LEN)) & ~ovf_q;
  assign match = full & (buf_q == code_q);
  assign fails_inc = (fails_q == FW'(MAX_ATTEMPTS)) ?
                     fails_q : fails_q + 1'b1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    fails_d = fails_q;
    code_d  = code_q;
    bad_d   = 1'b0;
    chg_d   = 1'b0;
    push    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      LOCKED: begin
        if (act) begin
          unique case (1'b1)
            is_digit(digit):      push = 1'b1;
            digit == KEY_CLEAR:   clr = 1'b1;
            digit == KEY_ENTER:   state_d = CHECK;
            default: ;
          endcase
        end else if (t_exp) begin
          clr = 1'b1;
        end
      end
      CHECK: begin
        clr = 1'b1;
        if (match) begin
          state_d = UNLOCKED;
          fails_d = '0;
        end else begin
          bad_d   = 1'b1;
          fails_d = fails_inc;
          state_d = (fails_inc == FW'(MAX_ATTEMPTS)) ?
                    LOCKOUT : LOCKED;
        end
      end
      UNLOCKED: begin
        if (act) begin
          unique case (1'b1)
            digit == KEY_ARM:   state_d = LOCKED;
            digit == KEY_ENTER: begin
              state_d = PROGRAM;
              clr     = 1'b1;
            end
            default: ;
          endcase
        end else if (t_exp) begin
          state_d = LOCKED;
        end
      end
      PROGRAM: begin
        if (act) begin
          unique case (1'b1)
            is_digit(digit):    push = 1'b1;
            digit == KEY_CLEAR: clr = 1'b1;
            digit == KEY_ARM: begin
              state_d = UNLOCKED;
              clr     = 1'b1;
            end
            digit == KEY_ENTER: begin
              state_d = UNLOCKED;
              clr     = 1'b1;
              if (full) begin
                code_d = buf_q;
                chg_d  = 1'b1;
              end else begin
                bad_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (t_exp) begin
          state_d = LOCKED;
          clr     = 1'b1;
        end
      end
      LOCKOUT: begin
        if (t_exp) begin
          state_d = LOCKED;
          fails_d = '0;
        end
      end
      default: state_d = LOCKED;
    endcase
    // A digit beyond CODE_LEN only marks the entry as bad.
    if (push) begin
      if (cnt_q == CW'(CODE_LEN)) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = (buf_q << 4) | BW'(digit);
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clr) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Any accepted key restarts the interval of the state it lands in.
  assign t_load = (act & (state_q != LOCKOUT) & (state_q != CHECK)) |
                  (state_q == CHECK);
  assign t_en   = (state_q == LOCKED) ? (cnt_q != '0) : 1'b1;

  always_comb begin
    case (state_d)
      LOCKED:  t_val = TW'(TIMEOUT_CYCLES);
      LOCKOUT: t_val = TW'(LOCKOUT_CYCLES);
      default: t_val = TW'(RELOCK_CYCLES);
    endcase
  end

  passcode_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_val),
    .enable     (t_en),
    .expired    (t_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fails_q <= '0;
      code_q  <= DEFAULT_CODE;
      bad_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fails_q <= fails_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
      chg_q   <= chg_d;
    end
  end

  assign locked      = (state_q == LOCKED) | (state_q == CHECK) |
                       (state_q == LOCKOUT);
  assign unlocked    = (state_q == UNLOCKED) | (state_q == PROGRAM);
  assign alarm       = (state_q == LOCKOUT);
  assign programming = (state_q == PROGRAM);
  assign entry_count = cnt_q;
  assign bad_code    = bad_q;
  assign code_changed = chg_q;

endmodule

// File: tb/tb_passcode_controller.sv
// Self-checking bench: directed vector table, hand sequences
// for timers and reset, and random keys against a model.
module tb_passcode_controller;

  localparam bit [3:0] K_A = 4'hA;
  localparam bit [3:0] K_B = 4'hB;
  localparam bit [3:0] K_C = 4'hC;
  localparam bit [3:0] K_E = 4'hE;

  localparam int S_LK = 0;
  localparam int S_CK = 1;
  localparam int S_UL = 2;
  localparam int S_PG = 3;
  localparam int S_LO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit = 4'h0;
  logic       valid = 1'b0;
  logic       locked, unlocked, alarm, programming;
  logic [2:0] entry_count;
  logic       bad_code, code_changed;

  int checks = 0;
  int errors = 0;

  passcode_controller #(
    .TIMEOUT_CYCLES (20),
    .RELOCK_CYCLES  (40),
    .LOCKOUT_CYCLES (60)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digit        (digit),
    .valid        (valid),
    .locked       (locked),
    .unlocked     (unlocked),
    .alarm        (alarm),
    .programming  (programming),
    .entry_count  (entry_count),
    .bad_code     (bad_code),
    .code_changed (code_changed)
  );

  always #5 clk = ~clk;

  // Reference model: entry kept as a digit list, timers as
  // "enabled cycles since the interval started".
  int mst;
  int dq[$];
  bit movf;
  int mfails;
  int mcode[4];
  bit mbad, mchg;
  int tidle, tlim;
  bit trun;

  task automatic model_reset();
    mst = S_LK;
    dq.delete();
    movf = 0;
    mfails = 0;
    mcode = '{1, 2, 3, 4};
    mbad = 0;
    mchg = 0;
    trun = 0;
    tidle = 0;
    tlim = 0;
  endtask

  function automatic bit code_match();
    if (dq.size() != 4 || movf) return 0;
    for (int i = 0; i < 4; i++)
      if (dq[i] != mcode[i]) return 0;
    return 1;
  endfunction

  task automatic add_digit(input int d);
    if (dq.size() == 4) movf = 1;
    else dq.push_back(d);
  endtask

  task automatic model_step(input bit v, input int d);
    bit act, fire, en, clr, ld;
    int nst;
    act = v && (d <= 9 || d == 10 || d == 12 || d == 14);
    en = (mst != S_LK) || (dq.size() > 0);
    fire = 0;
    if (trun && en) begin
      tidle++;
      if (tidle == tlim) begin
        fire = 1;
        trun = 0;
      end
    end
    nst = mst;
    clr = 0;
    mbad = 0;
    mchg = 0;
    case (mst)
      S_LK: begin
        if (act) begin
          if (d <= 9) add_digit(d);
          else if (d == 12) clr = 1;
          else if (d == 14) nst = S_CK;
        end else if (fire) clr = 1;
      end
      S_CK: begin
        if (code_match()) begin
          nst = S_UL;
          mfails = 0;
        end else begin
          mbad = 1;
          if (mfails < 3) mfails++;
          nst = (mfails >= 3) ? S_LO : S_LK;
        end
        clr = 1;
      end
      S_UL: begin
        if (act) begin
          if (d == 10) nst = S_LK;
          else if (d == 14) begin
            nst = S_PG;
            clr = 1;
          end
        end else if (fire) nst = S_LK;
      end
      S_PG: begin
        if (act) begin
          if (d <= 9) add_digit(d);
          else if (d == 12) clr = 1;
          else if (d == 10) begin
            nst = S_UL;
            clr = 1;
          end else if (d == 14) begin
            if (dq.size() == 4 && !movf) begin
              for (int i = 0; i < 4; i++) mcode[i] = dq[i];
              mchg = 1;
            end else mbad = 1;
            nst = S_UL;
            clr = 1;
          end
        end else if (fire) begin
          nst = S_LK;
          clr = 1;
        end
      end
      default: begin
        if (fire) begin
          nst = S_LK;
          mfails = 0;
        end
      end
    endcase
    ld = (act && mst != S_LO && mst != S_CK) || (mst == S_CK);
    if (ld) begin
      trun = 1;
      tidle = 0;
      tlim = (nst == S_LK) ? 20 : (nst == S_LO) ? 60 : 40;
    end
    if (clr) begin
      dq.delete();
      movf = 0;
    end
    mst = nst;
  endtask

  function automatic int pk(input bit lk, ul, al, pg,
                            input int cnt, input bit bad, chg);
    bit [2:0] c;
    c = 3'(cnt);
    return int'({lk, ul, al, pg, c, bad, chg});
  endfunction

  function automatic int mvec();
    return pk(mst == S_LK || mst == S_CK || mst == S_LO,
              mst == S_UL || mst == S_PG, mst == S_LO,
              mst == S_PG, dq.size(), mbad, mchg);
  endfunction

  function automatic int dvec();
    return int'({locked, unlocked, alarm, programming,
                 entry_count, bad_code, code_changed});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit v, input bit [3:0] d);
    valid = v;
    digit = d;
    @(posedge clk);
    model_step(v, int'(d));
    #1;
    valid = 1'b0;
    chk("model", dvec(), mvec());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit       v;
    bit [3:0] d;
    int       exp;
  } vec_t;

  vec_t tab[$];

  task automatic row(input bit v, input bit [3:0] d,
                     input bit lk, ul, al, pg,
                     input int cnt, input bit bad, chg);
    vec_t r;
    r.v = v;
    r.d = d;
    r.exp = pk(lk, ul, al, pg, cnt, bad, chg);
    tab.push_back(r);
  endtask

  task automatic lk(input bit [3:0] d, input int cnt);
    row(1, d, 1, 0, 0, 0, cnt, 0, 0);
  endtask

  task automatic pg(input bit [3:0] d, input int cnt);
    row(1, d, 0, 1, 0, 1, cnt, 0, 0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      tick(tab[i].v, tab[i].d);
      chk($sformatf("tab[%0d]", i), dvec(), tab[i].exp);
    end
  endtask

  task automatic enter_code(input int a, b, c, d);
    tick(1, 4'(a));
    tick(1, 4'(b));
    tick(1, 4'(c));
    tick(1, 4'(d));
    tick(1, K_E);
    tick(0, 4'h0);
  endtask

  int na;
  int hi;
  int r;

  initial begin
    // Unlock, overflow, clear, program, relock with new code.
    lk(1, 1); lk(2, 2); lk(3, 3); lk(4, 4); lk(K_E, 4);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0);
    lk(K_A, 0);
    lk(1, 1); lk(2, 2); lk(3, 3); lk(4, 4); lk(9, 4); lk(K_E, 4);
    row(0, 0, 1, 0, 0, 0, 0, 1, 0);
    lk(1, 1); lk(2, 2); lk(K_B, 2); lk(K_C, 0);
    lk(1, 1); lk(2, 2); lk(3, 3); lk(4, 4); lk(K_E, 4);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0);
    pg(K_E, 0); pg(9, 1); pg(8, 2); pg(7, 3); pg(6, 4);
    row(1, K_E, 0, 1, 0, 0, 0, 0, 1);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0);
    lk(K_A, 0);
    lk(1, 1); lk(2, 2); lk(3, 3); lk(4, 4); lk(K_E, 4);
    row(0, 0, 1, 0, 0, 0, 0, 1, 0);
    lk(9, 1); lk(8, 2); lk(7, 3); lk(6, 4); lk(K_E, 4);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0);
    lk(K_A, 0);
    na = tab.size();
    // After reset the default code applies again.
    lk(1, 1); lk(2, 2); lk(3, 3); lk(4, 4); lk(K_E, 4);
    row(0, 0, 0, 1, 0, 0, 0, 0, 0);
    lk(K_A, 0);

    do_reset();
    chk("reset", dvec(), pk(1, 0, 0, 0, 0, 0, 0));
    run_rows(0, na);
    do_reset();
    chk("reset2", dvec(), pk(1, 0, 0, 0, 0, 0, 0));
    run_rows(na, tab.size());

    // Partial entry timeout.
    tick(1, 1);
    tick(1, 2);
    for (int i = 0; i < 19; i++) tick(0, 0);
    chk("t4_hold", int'(entry_count), 2);
    tick(0, 0);
    chk("t4_clear", int'(entry_count), 0);
    tick(1, 3);
    tick(1, 4);
    tick(1, K_E);
    tick(0, 0);
    chk("t4_bad", int'({bad_code, alarm, locked}), 3'b101);
    enter_code(1, 2, 3, 4);
    tick(1, K_A);

    // Lockout after three failures.
    for (int k = 0; k < 3; k++) begin
      enter_code(1, 2, 3, 5);
      chk("t2_bad", int'(bad_code), 1);
      chk("t2_alarm", int'(alarm), (k == 2) ? 1 : 0);
    end
    hi = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1, 4'(i + 1));
      if (alarm) hi++;
    end
    tick(1, K_E);
    if (alarm) hi++;
    chk("t2_ignored", int'(entry_count), 0);
    for (int g = 0; g < 200 && alarm; g++) begin
      tick(0, 0);
      if (alarm) hi++;
    end
    chk("t2_lockout_len", hi, 60);
    chk("t2_after", int'({locked, alarm}), 2'b10);
    enter_code(1, 2, 3, 4);
    chk("t2_unlock", int'(unlocked), 1);

    // Automatic relock.
    hi = 1;
    for (int g = 0; g < 200 && unlocked; g++) begin
      tick(0, 0);
      if (unlocked) hi++;
    end
    chk("t6_relock_len", hi, 40);
    chk("t6_locked", int'(locked), 1);

    // Asynchronous reset in the middle of programming.
    enter_code(1, 2, 3, 4);
    tick(1, K_E);
    tick(1, 5);
    chk("t6_prog", int'({programming, entry_count}), 4'b1001);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_rst", dvec(), pk(1, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    enter_code(1, 2, 3, 4);
    chk("t6_default_code", int'(unlocked), 1);

    // Random keys against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        for (int i = 0; i < 4; i++) tick(1, 4'(mcode[i]));
        tick(1, K_E);
      end else if (r < 22) begin
        repeat ($urandom_range(1, 70)) tick(0, 4'($urandom_range(0, 15)));
      end else if (r < 70) begin
        tick(1, 4'($urandom_range(0, 9)));
      end else if (r < 78) begin
        tick(1, K_E);
      end else if (r < 84) begin
        tick(1, K_A);
      end else if (r < 89) begin
        tick(1, K_C);
      end else if (r < 92) begin
        tick(1, 4'($urandom_range(0, 2) * 2 + 11));
      end else begin
        repeat ($urandom_range(1, 3)) tick(0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
